rr_grant_arbiter4: RTL and testbench

- Round-robin arbiter that shares one resource between four requesters.
- The resource is one 4-way select whose one-hot select lines come from a 2-bit index.
- Emits a registered one-hot grant plus its 2-bit encoded index, so the grant can drive a one-hot select directly or feed a 2-to-4 decoder.
- Enforces a maximum hold time per grant. A requester that times out is locked out until it deasserts its request.

---
 rtl/rr_grant_arbiter4.sv | 139 +++++++++++++
 tb/tb_rr_grant_arbiter4.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter4.sv
// rr_grant_arbiter4 -- round-robin arbiter for four requesters with a
// per-grant hold-time limit and lockout of requesters that time out.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   req[3:0]   request, one bit per requester, held while resource needed
//   gnt[3:0]   registered one-hot grant, 0000 when no owner
//   gnt_idx    encoded index of current owner; holds last owner when idle
//   gnt_valid  high when gnt != 0000
//   timeout    one-cycle pulse in the cycle gnt drops due to hold-time limit
module rr_grant_arbiter4 #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01
  } state_t;

  localparam bit             TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [3:0]         mask_q, mask_d;
  // The priority pointer and the reported index are always the same value
  // (last owner, 3 after reset), so one register serves both.
  logic [1:0]         last_q, last_d;
  logic               valid_q, valid_d;
  logic               to_q, to_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         elig;
  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;
  logic               owner_req;
  logic               hit_timeout;

  assign elig        = req & ~mask_q;
  assign owner_req   = req[last_q];
  assign hit_timeout = TO_EN && (cnt_q == LIMIT);

  // First eligible requester searching last+1, last+2, last+3, last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      mask_q  <= '0;
      last_q  <= 2'b11;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GRANT;
      GRANT:   if (!owner_req || hit_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    gnt_d  = '0;
    last_d = last_q;
    cnt_d  = cnt_q;
    to_d   = 1'b0;
    // Lockout clears for any requester that has let go.
    mask_d = mask_q & req;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d  = 4'(1) << win_idx;
          last_d = win_idx;
          cnt_d  = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!owner_req) begin
          gnt_d = '0;
        end else if (hit_timeout) begin
          to_d           = 1'b1;
          mask_d[last_q] = 1'b1;
        end else begin
          gnt_d = gnt_q;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  always_comb valid_d = |gnt_d;

  assign gnt       = gnt_q;
  assign gnt_idx   = last_q;
  assign gnt_valid = valid_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// tb_rr_grant_arbiter4 -- directed and randomized checks of rr_grant_arbiter4
// against a behavioural ownership model (owner, hold count, lockout set).
module tb_rr_grant_arbiter4;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       m_owner = -1;
  int       m_last  = 3;
  int       m_held  = 0;
  bit [3:0] m_mask  = '0;
  bit       m_to    = 1'b0;

  always #5 clk = ~clk;

  rr_grant_arbiter4 #(.CNT_W(8), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always @(posedge clk) begin : model
    bit [3:0] nm;
    int w;
    int c;
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 3;
      m_held  = 0;
      m_mask  = '0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      nm   = m_mask & req;
      if (m_owner < 0) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (w < 0 && req[c] && !m_mask[c]) w = c;
        end
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_held  = 1;
        end
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else if (TO != 0 && m_held == TO) begin
        nm[m_owner] = 1'b1;
        m_owner     = -1;
        m_to        = 1'b1;
      end else begin
        m_held++;
      end
      m_mask = nm;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare all outputs to the model.
  task automatic step();
    @(negedge clk);
    check("gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
    check("gnt_idx", int'(gnt_idx), m_last);
    check("gnt_valid", int'(gnt_valid), (m_owner < 0) ? 0 : 1);
    check("timeout", int'(timeout), int'(m_to));
    check("gnt_onehot0", int'($onehot0(gnt)), 1);
  endtask

  initial begin
    int e_gnt;
    int e_to;

    // Reset with all requests high
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) begin
      step();
      check("rst_gnt", int'(gnt), 0);
      check("rst_idx", int'(gnt_idx), 3);
      check("rst_valid", int'(gnt_valid), 0);
      check("rst_to", int'(timeout), 0);
    end

    // Rotation under full load: 4 grant cycles + timeout cycle per requester
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      step();
      if (c / 5 < 4) begin
        e_gnt = (c % 5 < 4) ? (1 << (c / 5)) : 0;
        e_to  = (c % 5 == 4) ? 1 : 0;
      end else begin
        e_gnt = 0;
        e_to  = 0;
      end
      check("rot_gnt", int'(gnt), e_gnt);
      check("rot_to", int'(timeout), e_to);
    end

    // Single requester
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n = 1'b1;
    req   = 4'b0100;
    repeat (3) begin
      step();
      check("single_gnt", int'(gnt), 4);
      check("single_idx", int'(gnt_idx), 2);
      check("single_valid", int'(gnt_valid), 1);
    end
    req = 4'b0000;
    step();
    check("single_rel_gnt", int'(gnt), 0);
    check("single_rel_to", int'(timeout), 0);

    // Pointer wrap: last owner 2, search 3,0,1,2
    req = 4'b0011;
    step();
    check("wrap_gnt", int'(gnt), 1);
    req = 4'b0000;
    step();
    step();

    // Reset mid-grant
    req = 4'b0010;
    step();
    check("midrst_pre", int'(gnt), 2);
    step();
    rst_n = 1'b0;
    step();
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_to", int'(timeout), 0);
    rst_n = 1'b1;
    req   = 4'b0000;
    step();

    // Lockout and release
    req = 4'b0001;
    repeat (4) begin
      step();
      check("lock_hold", int'(gnt), 1);
    end
    step();
    check("lock_to_gnt", int'(gnt), 0);
    check("lock_to_pulse", int'(timeout), 1);
    repeat (3) begin
      step();
      check("lock_out", int'(gnt), 0);
    end
    req = 4'b0000;
    step();
    req = 4'b0001;
    step();
    check("lock_regrant", int'(gnt), 1);
    req = 4'b0000;
    step();
    step();

    // Deassert exactly on the timeout cycle
    req = 4'b1000;
    repeat (4) step();
    check("tocyc_hold", int'(gnt), 8);
    req = 4'b0000;
    step();
    check("tocyc_gnt", int'(gnt), 0);
    check("tocyc_to", int'(timeout), 0);
    req = 4'b1000;
    step();
    check("tocyc_nomask", int'(gnt), 8);
    req = 4'b0000;
    step();
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (req[b]) begin
          if ($urandom_range(7) == 0) req[b] = 1'b0;
        end else begin
          if ($urandom_range(3) == 0) req[b] = 1'b1;
        end
      end
      rst_n = ($urandom_range(249) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
